// File: rtl/channel_pkg.sv
// channel_pkg: shared word width, default timeout and FSM encoding for the channel arbiter
package channel_pkg;
    localparam int DATA_W      = 7;
    localparam int TIMEOUT_DEF = 64;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search for the first set request starting at rr_ptr
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    // Walk offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            idx = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : ID_W'(sum);
            if (req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/channel_arbiter.sv
// channel_arbiter: round-robin sharing of one serial sender between NUM_REQ requesters
module channel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = channel_pkg::DATA_W,
    parameter int TIMEOUT = channel_pkg::TIMEOUT_DEF,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      tx_done,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    output logic [NUM_REQ-1:0]        ack,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      timeout_err
);
    import channel_pkg::*;
    localparam int CNT_W = $clog2(TIMEOUT);
    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               to_q, to_d;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );
    // State and datapath registers; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end
    // Per-word sequencing: grant, latch word, start, wait for done or timeout, acknowledge
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                grant_d = pick_id;
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = req_data[grant_q*DATA_W +: DATA_W];
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (tx_done) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                rr_d    = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign tx_data     = data_q;
    assign tx_start    = state_q == START;
    assign busy        = state_q != IDLE;
    assign grant_id    = grant_q;
    assign timeout_err = err_q;
    assign ack         = (state_q == DONE && !to_q) ? NUM_REQ'(1) << grant_q : '0;
endmodule

// File: tb/tb_channel_arbiter.sv
// tb_channel_arbiter: scoreboard bench for the round-robin channel arbiter
module tb_channel_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [27:0] req_data = {7'h44, 7'h33, 7'h22, 7'h11};
    logic        tx_done = 1'b0;
    logic [6:0]  tx_data;
    logic        tx_start;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    int total = 0;
    int passed = 0;
    int exp_id[$];
    int exp_data[$];
    int exp_ack[$];
    int n;

    channel_arbiter #(.NUM_REQ(4), .DATA_W(7), .TIMEOUT(64), .ID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .tx_done     (tx_done),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        if (k > 0) #1;
    endtask

    task automatic expect_xfer(input int id, input int data, input bit acked);
        exp_id.push_back(id);
        exp_data.push_back(data);
        if (acked) exp_ack.push_back(1 << id);
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!tx_start && cyc < 100) begin
            tick(1);
            cyc++;
        end
        if (!tx_start) begin
            total++;
            $display("FAIL wait_start: no tx_start after %0d cycles, required within 100", cyc);
        end
    endtask

    // Waits for tx_start, lets dly WAIT cycles pass, then pulses tx_done; returns in DONE
    task automatic do_xfer(input int dly, output int cyc);
        wait_start(cyc);
        tick(1 + dly);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    // Monitor: every tx_start and every ack is matched against the scoreboard
    always @(negedge clk) begin
        if (tx_start) begin
            if (exp_id.size() == 0) begin
                total++;
                $display("FAIL unexpected_start: grant %0d data %0h, required no tx_start", grant_id, tx_data);
            end else begin
                chk("start_grant_id", int'(grant_id), exp_id.pop_front());
                chk("start_tx_data", int'(tx_data), exp_data.pop_front());
            end
        end
        if (ack != 0) begin
            chk("ack_onehot", int'($onehot(ack)), 1);
            if (exp_ack.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack: got %b, required 0000", ack);
            end else begin
                chk("ack_value", int'(ack), exp_ack.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Single request with late tx_done and req_data changed after LOAD
        req_data = {7'h44, 7'h33, 7'h22, 7'b1010111};
        expect_xfer(0, 7'h57, 1);
        req = 4'b0001;
        tick(1);
        chk("lat_start_early", int'(tx_start), 0);
        chk("busy_after_req", int'(busy), 1);
        tick(1);
        chk("lat_start_n2", int'(tx_start), 1);
        tick(1);
        req_data[6:0] = 7'h00;
        tick(19);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("single_ack", int'(ack), 1);
        chk("single_busy_done", int'(busy), 1);
        chk("tx_data_stable", int'(tx_data), 7'h57);
        req = 4'b0000;
        tick(1);
        chk("single_busy_drop", int'(busy), 0);
        req_data = {7'h44, 7'h33, 7'h22, 7'h11};

        // All requesting from rr_ptr = 0: grants 0,1,2,3,0 back to back
        do_reset();
        expect_xfer(0, 7'h11, 1);
        expect_xfer(1, 7'h22, 1);
        expect_xfer(2, 7'h33, 1);
        expect_xfer(3, 7'h44, 1);
        expect_xfer(0, 7'h11, 1);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            do_xfer(0, n);
            if (i > 0) chk("word_interval", n, 3);
        end
        req = 4'b0000;
        tick(1);

        // Pointer wrap: serve 2, then 1001 gives 3 then 0
        expect_xfer(2, 7'h33, 1);
        expect_xfer(3, 7'h44, 1);
        expect_xfer(0, 7'h11, 1);
        req = 4'b0100;
        do_xfer(2, n);
        req = 4'b1001;
        do_xfer(1, n);
        req = 4'b0001;
        do_xfer(1, n);
        req = 4'b0000;
        tick(1);

        // Reset mid-WAIT, then pending 0101 served from rr_ptr = 0
        expect_xfer(0, 7'h11, 0);
        req = 4'b0001;
        wait_start(n);
        tick(3);
        rst = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tx_data", int'(tx_data), 0);
        chk("midrst_grant_id", int'(grant_id), 0);
        chk("midrst_ack", int'(ack), 0);
        chk("midrst_tx_start", int'(tx_start), 0);
        req = 4'b0101;
        #9;
        rst = 1'b1;
        expect_xfer(0, 7'h11, 1);
        expect_xfer(2, 7'h33, 1);
        do_xfer(0, n);
        req = 4'b0100;
        do_xfer(4, n);
        req = 4'b0000;
        tick(1);

        // req[1] dropped during WAIT still gets its ack
        expect_xfer(1, 7'h22, 1);
        req = 4'b0010;
        wait_start(n);
        tick(2);
        req = 4'b0000;
        tick(3);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("late_drop_ack", int'(ack), 4'b0010);
        tick(1);

        // tx_done in the very cycle the timeout would fire: done wins
        expect_xfer(3, 7'h44, 1);
        req = 4'b1000;
        wait_start(n);
        tick(64);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("tie_ack", int'(ack), 4'b1000);
        chk("tie_no_err", int'(timeout_err), 0);
        req = 4'b0000;
        tick(1);

        // Timeout: no tx_done, error after 64 WAIT cycles, no ack, sticky
        expect_xfer(1, 7'h22, 0);
        req = 4'b0010;
        wait_start(n);
        tick(64);
        chk("to_err_before", int'(timeout_err), 0);
        chk("to_busy_wait", int'(busy), 1);
        tick(1);
        chk("to_err_set", int'(timeout_err), 1);
        chk("to_no_ack", int'(ack), 0);
        req = 4'b0000;
        tick(1);
        chk("to_idle", int'(busy), 0);

        // Stray tx_done in IDLE is ignored
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("stray_busy", int'(busy), 0);
        tick(5);
        chk("stray_busy_later", int'(busy), 0);
        chk("err_sticky", int'(timeout_err), 1);
        do_reset();
        chk("err_cleared", int'(timeout_err), 0);

        chk("sb_start_empty", exp_id.size(), 0);
        chk("sb_ack_empty", exp_ack.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
